up_memory: RTL and testbench
============================

// Module: up_memory
// PURPOSE
//   Memory and memory-mapped I/O stage directly downstream of up_controller.
//   Consumes ale/mem_we and the shared datapath bus; holds program and data RAM.
//   Returns read data, the mem_re valid pulse and the level interrupt "int" back to the controller.
//   Interrupt source is a prescaled reload timer.
// PARAMETERS
//   ADDR_W    8      address/data bus width (bits)
//   IO_BASE   8'hF0  first I/O address; RAM covers 0..IO_BASE-1, I/O covers IO_BASE..IO_BASE+15
//   PRESCALE  16     clocks per timer tick (>=1)
// PORTS
//   clk       in   1       single system clock, rising edge
//   nRst      in   1       asynchronous active-low reset
//   ale       in   1       address latch enable: bus_in carries address this cycle
//   mem_we    in   1       write strobe: bus_in carries write data this cycle
//   bus_in    in   ADDR_W  datapath bus (address during ale, data during mem_we)
//   rd_data   out  ADDR_W  read data for the latched address
//   mem_re    out  1       read-valid pulse, high the cycle after ale
//   port_in   in   8       asynchronous external input pins
//   port_out  out  8       registered external output pins
//   int       out  1       timer interrupt request (level)
// BEHAVIOUR
//   Reset (nRst low, async): addr_q=0, mem_re=0, port_out=0, sync flops=0, reload=0, ctrl=0,
//     count=0, prescaler=0, flag=0, int=0. RAM contents are not reset (undefined).
//   Address latch: ale high at edge -> addr_q<=bus_in; mem_re<=1 for exactly that next cycle, else 0.
//   Read: rd_data is combinational from addr_q; valid the cycle after ale (FETCH_READ/EXECUTE_2).
//   Write: mem_we high at edge -> write bus_in at addr_q (the value before this edge).
//   ale+mem_we same cycle: write uses old addr_q; addr_q then updates. The controller never does this.
//   RAM: addr_q < IO_BASE -> rd_data = ram[addr_q]; write updates ram.
//   I/O map (offset from IO_BASE); unlisted offsets read 0 and ignore writes:
//     +0 PORT_OUT RW. +1 PORT_IN RO, 2-flop synchronised copy of port_in.
//     +2 RELOAD RW. +4 COUNT RO, current timer count.
//     +3 CTRL: bit0 EN RW, bit1 IE RW, bit7 FLAG read; write 1 to bit7 clears FLAG.
//     CTRL other bits read 0.
//   Timer:
//     - EN=0: prescaler and count hold.
//     - EN 0->1 write: count<=RELOAD, prescaler<=0.
//     - EN=1: prescaler counts 0..PRESCALE-1 and wraps; tick = wrap cycle.
//     - On tick: count==0 -> FLAG<=1, count<=RELOAD; else count<=count-1.
//       Period is (RELOAD+1)*PRESCALE clocks; RELOAD=0 fires every tick.
//     - RELOAD write while running takes effect at the next reload only.
//     - FLAG set and W1C in the same cycle: set wins.
//   int: registered, int<=FLAG&IE. Stays high until FLAG is cleared or IE is cleared.
//     The controller edge-detects int, so one level assertion causes one interrupt entry.
//   Reset mid-operation: all state above returns to reset values immediately; a pending write is lost.
// TESTING
//   1. Reset, then ale bus_in=0x10; next cycle mem_we bus_in=0xA5; ale 0x10 again.
//      -> mem_re=1 one cycle later, rd_data=0xA5.
//   2. Write ram[0x20]=0x11, then ale 0x20 and mem_we 0x22 in the same cycle; ale 0x20.
//      -> rd_data=0x22; ram[old addr_q] not corrupted.
//   3. Set port_in=0x3C; read at IO_BASE+1 -> 0x3C no earlier than 2 clocks after the change.
//      Write IO_BASE+0=0x81 -> port_out=0x81.
//   4. PRESCALE=16, RELOAD=3, CTRL=0x03 -> FLAG sets and int rises 64 clocks (+1 for int register)
//      after enable. Write CTRL=0x83 -> int falls next cycle; re-fires after another 64 clocks.
//   5. FLAG set on the same edge as the W1C write -> FLAG stays 1.
//      RELOAD=0 -> FLAG every 16 clocks.
//   6. Assert nRst mid-count with int=1 -> int, port_out, COUNT and CTRL read 0 immediately.
//      mem_re stays 0 until the next ale.

Source files
------------

// File: rtl/up_memory.sv
// -----------------------------------------------------------------------------
// up_memory
//   Memory and memory-mapped I/O stage that sits directly behind up_controller.
//   It latches an address on ale and writes bus data on mem_we. It holds the
//   program/data RAM below IO_BASE and a 16-entry I/O window at IO_BASE. The
//   window contains output/input ports and a prescaled reload timer that
//   raises a level interrupt.
//
//   Ports
//     clk       in   1       system clock, rising edge
//     nRst      in   1       asynchronous active-low reset
//     ale       in   1       bus_in carries an address this cycle
//     mem_we    in   1       bus_in carries write data this cycle
//     bus_in    in   ADDR_W  shared datapath bus
//     rd_data   out  ADDR_W  read data for the latched address (combinational)
//     mem_re    out  1       read-valid pulse, high the cycle after ale
//     port_in   in   8       asynchronous external input pins
//     port_out  out  8       registered external output pins
//     int_req   out  1       timer interrupt request (level). "int" is a
//                            reserved word, so the controller's int input
//                            connects here.
//
//   I/O window (offset from IO_BASE); any offset not listed reads 0 and
//   ignores writes:
//     0 PORT_OUT rw   1 PORT_IN ro   2 RELOAD rw   3 CTRL   4 COUNT ro
//     CTRL: bit0 EN rw, bit1 IE rw, bit7 FLAG (reads FLAG; write 1 clears it)
//
//   ADDR_W is assumed to be at least 8, because the ports and CTRL are byte
//   wide.
// -----------------------------------------------------------------------------
module up_memory #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] IO_BASE  = 8'hF0,
    parameter int unsigned       PRESCALE = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              ale,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] bus_in,
    output logic [ADDR_W-1:0] rd_data,
    output logic              mem_re,
    input  logic [7:0]        port_in,
    output logic [7:0]        port_out,
    output logic              int_req
);

    localparam int unsigned       RAM_DEPTH = 32'(IO_BASE);
    localparam int unsigned       RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned       PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [ADDR_W-1:0] ZERO      = {ADDR_W{1'b0}};

    // Read view of CTRL: only FLAG, IE and EN are implemented.
    function automatic logic [ADDR_W-1:0] ctrl_word(input logic flag, input logic ie,
                                                     input logic en);
        ctrl_word = ADDR_W'({flag, 5'b00000, ie, en});
    endfunction

    logic [ADDR_W-1:0] addr_r;
    logic              mem_re_r;
    logic              run_r;
    logic [7:0]        port_out_r;
    logic [7:0]        sync1_r;
    logic [7:0]        sync2_r;
    logic [ADDR_W-1:0] reload_r;
    logic [ADDR_W-1:0] count_r;
    logic [PW-1:0]     presc_r;
    logic              en_r;
    logic              ie_r;
    logic              flag_r;
    logic              int_r;

    logic [ADDR_W-1:0] ram_r [RAM_DEPTH];

    logic              ram_hit_s;
    logic              io_hit_s;
    logic [ADDR_W-1:0] io_off_full_s;
    logic [3:0]        io_off_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              wr_port_s;
    logic              wr_reload_s;
    logic              wr_ctrl_s;
    logic              en_rise_s;
    logic              tick_s;
    logic              count_zero_s;
    logic [ADDR_W-1:0] io_rd_s;

    // Address decode and write strobes, all derived from the latched address.
    always_comb begin
        ram_hit_s     = (addr_r < IO_BASE);
        io_off_full_s = addr_r - IO_BASE;
        io_hit_s      = !ram_hit_s && (io_off_full_s < ADDR_W'(16));
        io_off_s      = io_off_full_s[3:0];
        ram_idx_s     = addr_r[RAM_AW-1:0];
        wr_port_s     = mem_we && io_hit_s && (io_off_s == 4'd0);
        wr_reload_s   = mem_we && io_hit_s && (io_off_s == 4'd2);
        wr_ctrl_s     = mem_we && io_hit_s && (io_off_s == 4'd3);
        en_rise_s     = wr_ctrl_s && bus_in[0] && !en_r;
        tick_s        = en_r && (presc_r == PRESC_MAX);
        count_zero_s  = (count_r == ZERO);
    end

    // I/O register read multiplexer.
    always_comb begin
        io_rd_s = ZERO;
        case (io_off_s)
            4'd0:    io_rd_s = ADDR_W'(port_out_r);
            4'd1:    io_rd_s = ADDR_W'(sync2_r);
            4'd2:    io_rd_s = reload_r;
            4'd3:    io_rd_s = ctrl_word(flag_r, ie_r, en_r);
            4'd4:    io_rd_s = count_r;
            default: io_rd_s = ZERO;
        endcase
    end

    // Read data follows the latched address with no extra register stage.
    always_comb begin
        if (ram_hit_s) begin
            rd_data = ram_r[ram_idx_s];
        end else if (io_hit_s) begin
            rd_data = io_rd_s;
        end else begin
            rd_data = ZERO;
        end
    end

    // Address latch and the one-cycle read-valid pulse.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr_r   <= ZERO;
            mem_re_r <= 1'b0;
        end else begin
            if (ale) begin
                addr_r <= bus_in;
            end
            mem_re_r <= ale;
        end
    end

    // Write enable for the un-reset RAM. It stays low while held in reset, so a
    // write that was in progress when reset arrived does not land.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // RAM array. The write uses addr_r as it was before this edge.
    always_ff @(posedge clk) begin
        if (run_r && mem_we && ram_hit_s) begin
            ram_r[ram_idx_s] <= bus_in;
        end
    end

    // Output port register and a two-flop synchroniser for the input pins.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            port_out_r <= 8'h00;
            sync1_r    <= 8'h00;
            sync2_r    <= 8'h00;
        end else begin
            if (wr_port_s) begin
                port_out_r <= bus_in[7:0];
            end
            sync1_r <= port_in;
            sync2_r <= sync1_r;
        end
    end

    // Timer: control bits, prescaler, reload counter and the sticky FLAG.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            reload_r <= ZERO;
            en_r     <= 1'b0;
            ie_r     <= 1'b0;
            presc_r  <= {PW{1'b0}};
            count_r  <= ZERO;
            flag_r   <= 1'b0;
        end else begin
            if (wr_reload_s) begin
                reload_r <= bus_in;
            end
            if (wr_ctrl_s) begin
                en_r <= bus_in[0];
                ie_r <= bus_in[1];
            end
            // A running counter only picks up a new RELOAD on its next reload.
            if (en_rise_s) begin
                count_r <= reload_r;
                presc_r <= {PW{1'b0}};
            end else if (en_r) begin
                presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
                if (tick_s) begin
                    count_r <= count_zero_s ? reload_r : count_r - ADDR_W'(1);
                end
            end
            // When the timer sets FLAG on the same edge that software clears
            // it, the set wins and the event is not lost.
            if (tick_s && count_zero_s) begin
                flag_r <= 1'b1;
            end else if (wr_ctrl_s && bus_in[7]) begin
                flag_r <= 1'b0;
            end
        end
    end

    // Registered interrupt level. The controller edge-detects it.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            int_r <= 1'b0;
        end else begin
            int_r <= flag_r & ie_r;
        end
    end

    assign mem_re   = mem_re_r;
    assign port_out = port_out_r;
    assign int_req  = int_r;

endmodule

// File: tb/tb_up_memory.sv
// -----------------------------------------------------------------------------
// tb_up_memory
//   Bench for up_memory. Every ale pushes an expected read result onto a
//   scoreboard. The scoreboard entry is popped and compared when the DUT raises
//   mem_re. Timer timing is checked against the cycle on which the bench
//   enabled the timer.
// -----------------------------------------------------------------------------
module tb_up_memory;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  IO_BASE  = 8'hF0;
    localparam int unsigned PRESCALE = 16;

    logic       clk = 1'b0;
    logic       nRst;
    logic       ale;
    logic       mem_we;
    logic [7:0] bus_in;
    logic [7:0] rd_data;
    logic       mem_re;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       int_req;

    up_memory #(
        .ADDR_W  (ADDR_W),
        .IO_BASE (IO_BASE),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .ale     (ale),
        .mem_we  (mem_we),
        .bus_in  (bus_in),
        .rd_data (rd_data),
        .mem_re  (mem_re),
        .port_in (port_in),
        .port_out(port_out),
        .int_req (int_req)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_n  = 0;
    int seen;
    int en_c;
    int en2;

    logic [7:0] sb_exp  [$];
    bit         sb_care [$];
    string      sb_tag  [$];

    logic [7:0] pat_a [4] = '{8'h00, 8'h01, 8'h7F, 8'hEF};
    logic [7:0] pat_d [4] = '{8'h5A, 8'hC3, 8'h0F, 8'hE7};

    // Free-running edge counter used as the timing reference.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one entry per mem_re pulse.
    always @(negedge clk) begin
        if (mem_re === 1'b1) begin
            if (sb_exp.size() == 0) begin
                chk("spurious_mem_re", 32'd1, 32'd0);
            end else begin
                string      t;
                logic [7:0] e;
                bit         c;
                t = sb_tag.pop_front();
                e = sb_exp.pop_front();
                c = sb_care.pop_front();
                if (c) chk(t, {24'h0, rd_data}, {24'h0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ale(input logic [7:0] a, input bit care, input logic [7:0] e,
                          input string tag);
        sb_exp.push_back(e);
        sb_care.push_back(care);
        sb_tag.push_back(tag);
        ale    = 1'b1;
        bus_in = a;
        cyc();
        ale    = 1'b0;
    endtask

    task automatic do_we(input logic [7:0] d);
        mem_we = 1'b1;
        bus_in = d;
        cyc();
        mem_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        do_ale(a, 1'b0, 8'h00, "wr");
        do_we(d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
        do_ale(a, 1'b1, e, tag);
        cyc();
        chk({tag, "_drain"}, 32'(sb_exp.size()), 32'd0);
        chk({tag, "_re_low"}, {31'h0, mem_re}, 32'd0);
    endtask

    task automatic wait_int(input int limit, output int when);
        int n = 0;
        while (int_req !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        when = (int_req === 1'b1) ? cyc_n : -1;
    endtask

    task automatic idle_until(input int t);
        while (cyc_n < t) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRst    = 1'b0;
        ale     = 1'b0;
        mem_we  = 1'b0;
        bus_in  = 8'h00;
        port_in = 8'h00;
        #12;
        chk("rst_mem_re", {31'h0, mem_re}, 32'd0);
        chk("rst_port_out", {24'h0, port_out}, 32'd0);
        chk("rst_int", {31'h0, int_req}, 32'd0);
        cyc();
        nRst = 1'b1;
        cyc();
        cyc();

        // RAM write then read back, plus a few patterns up to the last RAM byte.
        wr(8'h10, 8'hA5);
        rd(8'h10, 8'hA5, "t1_ram");
        for (int i = 0; i < 4; i++) wr(pat_a[i], pat_d[i]);
        for (int i = 0; i < 4; i++) rd(pat_a[i], pat_d[i], $sformatf("ram_pat%0d", i));

        // ale and mem_we in the same cycle: the write lands at the old address.
        wr(8'h22, 8'h5A);
        wr(8'h20, 8'h11);
        sb_exp.push_back(8'h5A);
        sb_care.push_back(1'b1);
        sb_tag.push_back("t2_same");
        ale    = 1'b1;
        mem_we = 1'b1;
        bus_in = 8'h22;
        cyc();
        ale    = 1'b0;
        mem_we = 1'b0;
        cyc();
        rd(8'h20, 8'h22, "t2_old_addr");
        rd(8'h22, 8'h5A, "t2_new_addr");

        // Output port, unlisted offset, input synchroniser latency.
        wr(IO_BASE, 8'h81);
        chk("t3_port_out", {24'h0, port_out}, 32'h81);
        rd(IO_BASE, 8'h81, "t3_port_rd");
        wr(IO_BASE + 8'h05, 8'hFF);
        rd(IO_BASE + 8'h05, 8'h00, "t3_unlisted");
        port_in = 8'h3C;
        rd(IO_BASE + 8'h01, 8'h00, "t3_sync_1clk");
        rd(IO_BASE + 8'h01, 8'h3C, "t3_sync_2clk");

        // Timer with RELOAD=3: FLAG after 64 clocks, int one clock later.
        wr(IO_BASE + 8'h02, 8'h03);
        rd(IO_BASE + 8'h02, 8'h03, "t4_reload");
        wr(IO_BASE + 8'h03, 8'h03);
        en_c = cyc_n;
        idle_until(en_c + 20);
        rd(IO_BASE + 8'h04, 8'h02, "t4_count");
        rd(IO_BASE + 8'h03, 8'h03, "t4_ctrl_idle");
        wait_int(100, seen);
        chk("t4_int_rise", seen, en_c + 65);
        rd(IO_BASE + 8'h03, 8'h83, "t4_flag_set");
        do_we(8'h83);
        chk("t4_int_hold", {31'h0, int_req}, 32'd1);
        cyc();
        chk("t4_int_fall", {31'h0, int_req}, 32'd0);
        wait_int(100, seen);
        chk("t4_int_refire", seen, en_c + 129);

        // Stop, clear, and restart with RELOAD=0.
        do_we(8'h80);
        wr(IO_BASE + 8'h02, 8'h00);
        rd(IO_BASE + 8'h03, 8'h00, "t5_stopped");
        do_we(8'h03);
        en2 = cyc_n;
        idle_until(en2 + 15);
        do_we(8'h83);            // lands on the same edge that sets FLAG
        rd(IO_BASE + 8'h03, 8'h83, "t5_set_wins");
        do_we(8'h83);
        cyc();
        chk("t5_int_clr1", {31'h0, int_req}, 32'd0);
        wait_int(40, seen);
        chk("t5_period1", seen, en2 + 33);
        do_we(8'h83);
        cyc();
        chk("t5_int_clr2", {31'h0, int_req}, 32'd0);
        wait_int(40, seen);
        chk("t5_period2", seen, en2 + 49);

        // Reset while the timer is running and int is high.
        nRst = 1'b0;
        #1;
        chk("t6_int", {31'h0, int_req}, 32'd0);
        chk("t6_port_out", {24'h0, port_out}, 32'd0);
        chk("t6_mem_re", {31'h0, mem_re}, 32'd0);
        cyc();
        cyc();
        nRst = 1'b1;
        cyc();
        cyc();
        chk("t6_mem_re_idle", {31'h0, mem_re}, 32'd0);
        rd(IO_BASE + 8'h04, 8'h00, "t6_count");
        rd(IO_BASE + 8'h03, 8'h00, "t6_ctrl");
        rd(IO_BASE + 8'h02, 8'h00, "t6_reload");
        rd(IO_BASE, 8'h00, "t6_port_rd");
        rd(8'h10, 8'hA5, "t6_ram_kept");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
